// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// The datapath sends the opcode and receives the strobes, mux selects and status. ILLEGAL_TRAP_EN adds illegal_op.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             PCWrite, PCWriteCond, BNEq, IRd, IRWr, MemRd, MemWr, RegWrite;
    logic             RegDst, MemToReg, SESF, JE, ALUSrcA;
    logic [1:0]       R1Src, ALUSrcB, PCSrc;
    logic [2:0]       ALUCtrl;
    logic [3:0]       state_o;
    logic             halted;
    logic [CNT_W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_op;
`endif

    modport master (
        input  opcode,
`ifdef ILLEGAL_TRAP_EN
        output illegal_op,
`endif
        output PCWrite, PCWriteCond, BNEq, IRd, IRWr, MemRd, MemWr, RegWrite,
        output RegDst, MemToReg, SESF, JE, ALUSrcA,
        output R1Src, ALUSrcB, PCSrc, ALUCtrl,
        output state_o, halted, instret
    );

    modport slave (
        output opcode,
`ifdef ILLEGAL_TRAP_EN
        input  illegal_op,
`endif
        input  PCWrite, PCWriteCond, BNEq, IRd, IRWr, MemRd, MemWr, RegWrite,
        input  RegDst, MemToReg, SESF, JE, ALUSrcA,
        input  R1Src, ALUSrcB, PCSrc, ALUCtrl,
        input  state_o, halted, instret
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit RISC core: one state per clk, Moore strobes, instret and halt flag.
// Latency: R/ADDI/SW 4 cycles, LW 5, BEQ/BNE/JMP/JR 3. There is no backpressure; rst overrides everything.
// Build option ILLEGAL_TRAP_EN: opcode 0xF traps to HALT and sets a sticky illegal_op. Without it, 0xF is a NOP.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master ctl
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EX_R     = 4'd2;
    localparam logic [3:0] S_EX_I     = 4'd3;
    localparam logic [3:0] S_WB_ALU   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_JR       = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JR   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] R1_RB = 2'd1;
    localparam logic [1:0] R1_RA = 2'd2;

    logic [3:0]       state, state_nxt;
    logic [CNT_W-1:0] instret_q;
    logic             halted_q;

    logic       pc_write, pc_write_cond, bneq, ir_rd, ir_wr, mem_rd, mem_wr, reg_write;
    logic       mem_to_reg, sesf, je, alu_src_a;
    logic [1:0] r1_src, alu_src_b, pc_src;
    logic [2:0] alu_ctrl;

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (ctl.opcode <= 4'h6) begin
                    state_nxt = S_EX_R;
                end else begin
                    case (ctl.opcode)
                        OP_ADDI:        state_nxt = S_EX_I;
                        OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                        OP_JMP:         state_nxt = S_JUMP;
                        OP_JR:          state_nxt = S_JR;
                        OP_HALT:        state_nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                        default:        state_nxt = S_HALT;
`else
                        default:        state_nxt = S_FETCH;
`endif
                    endcase
                end
            end
            S_EX_R, S_EX_I: state_nxt = S_WB_ALU;
            S_MEM_ADDR:     state_nxt = (ctl.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:       state_nxt = S_MEM_WB;
            S_HALT:         state_nxt = S_HALT;
            default:        state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            // HALT never returns to FETCH, so it never retires.
            if (state_nxt == S_FETCH && state != S_FETCH)
                instret_q <= instret_q + CNT_W'(1);
            if (state_nxt == S_HALT)
                halted_q <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (state == S_DECODE && ctl.opcode == 4'hF)
            illegal_q <= 1'b1;
    end

    assign ctl.illegal_op = illegal_q;
`endif

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        bneq          = 1'b0;
        ir_rd         = 1'b0;
        ir_wr         = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        sesf          = 1'b0;
        je            = 1'b0;
        alu_src_a     = 1'b0;
        r1_src        = 2'd0;
        alu_src_b     = 2'd0;
        pc_src        = 2'd0;
        alu_ctrl      = ALU_ADD;

        if (state != S_FETCH) begin
            if (ctl.opcode <= 4'h6 || ctl.opcode == OP_LW || ctl.opcode == OP_SW)
                r1_src = R1_RB;
            else if (ctl.opcode == OP_ADDI)
                r1_src = R1_RA;
        end

        case (state)
            S_FETCH: begin
                ir_rd     = 1'b1;
                ir_wr     = 1'b1;
                alu_src_b = 2'd1;
                pc_src    = 2'd2;
                pc_write  = 1'b1;
            end
            S_DECODE:   alu_src_b = 2'd3;
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ctl.opcode[2:0];
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                sesf      = 1'b1;
            end
            S_WB_ALU:   reg_write = 1'b1;
            S_MEM_ADDR: alu_src_a = 1'b1;
            S_MEM_RD:   mem_rd = 1'b1;
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR:   mem_wr = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                bneq          = (ctl.opcode == OP_BNE);
            end
            S_JUMP: begin
                alu_src_b = 2'd2;
                je        = 1'b1;
                pc_src    = 2'd2;
                pc_write  = 1'b1;
            end
            S_JR: begin
                pc_src   = 2'd1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated combinationally so a reset cycle never issues a partial write.
    assign ctl.PCWrite     = pc_write      & ~rst;
    assign ctl.PCWriteCond = pc_write_cond & ~rst;
    assign ctl.BNEq        = bneq          & ~rst;
    assign ctl.IRd         = ir_rd         & ~rst;
    assign ctl.IRWr        = ir_wr         & ~rst;
    assign ctl.MemRd       = mem_rd        & ~rst;
    assign ctl.MemWr       = mem_wr        & ~rst;
    assign ctl.RegWrite    = reg_write     & ~rst;

    assign ctl.RegDst   = 1'b0;
    assign ctl.MemToReg = mem_to_reg;
    assign ctl.SESF     = sesf;
    assign ctl.JE       = je;
    assign ctl.ALUSrcA  = alu_src_a;
    assign ctl.R1Src    = r1_src;
    assign ctl.ALUSrcB  = alu_src_b;
    assign ctl.PCSrc    = pc_src;
    assign ctl.ALUCtrl  = alu_ctrl;
    assign ctl.state_o  = state;
    assign ctl.halted   = halted_q;
    assign ctl.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: an instruction-sequence model is checked every cycle, plus directed literal checks.
// A narrow counter is used so that the instret wrap is reachable in a short run.
module tb_multicycle_ctrl_fsm;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();
    multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .ctl(bus));

    typedef struct packed {
        logic       pcw, pcwc, bneq, ird, irwr, memrd, memwr, regwr;
        logic       regdst, memtoreg, sesf, je, alusrca;
        logic [1:0] r1src, alusrcb, pcsrc;
        logic [2:0] aluctrl;
    } ctl_t;

    ctl_t act;
    assign act = {bus.PCWrite, bus.PCWriteCond, bus.BNEq, bus.IRd, bus.IRWr, bus.MemRd, bus.MemWr,
                  bus.RegWrite, bus.RegDst, bus.MemToReg, bus.SESF, bus.JE, bus.ALUSrcA,
                  bus.R1Src, bus.ALUSrcB, bus.PCSrc, bus.ALUCtrl};

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Each opcode is a fixed list of visited states; index 0 is FETCH.
    function automatic int seq_len(input logic [3:0] op);
        if (op <= 4'h7 || op == 4'h9) return 4;
        if (op == 4'h8) return 5;
`ifdef ILLEGAL_TRAP_EN
        return 3;
`else
        if (op == 4'hF) return 2;
        return 3;
`endif
    endfunction

    function automatic logic [3:0] seq_state(input logic [3:0] op, input int i);
        if (i == 0) return 4'd0;
        if (i == 1) return 4'd1;
        if (i == 2) begin
            if (op <= 4'h6) return 4'd2;
            case (op)
                4'h7:       return 4'd3;
                4'h8, 4'h9: return 4'd5;
                4'hA, 4'hB: return 4'd9;
                4'hC:       return 4'd10;
                4'hD:       return 4'd11;
                default:    return 4'd12;
            endcase
        end
        if (i == 3) begin
            if (op <= 4'h7) return 4'd4;
            return (op == 4'h8) ? 4'd6 : 4'd8;
        end
        return 4'd7;
    endfunction

    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [3:0] op, input logic r);
        ctl_t c;
        c = '0;
        if (st != 4'd0) begin
            if (op <= 4'h6 || op == 4'h8 || op == 4'h9) c.r1src = 2'd1;
            else if (op == 4'h7) c.r1src = 2'd2;
        end
        case (st)
            4'd0:  begin c.ird = 1; c.irwr = 1; c.alusrcb = 2'd1; c.pcsrc = 2'd2; c.pcw = 1; end
            4'd1:  c.alusrcb = 2'd3;
            4'd2:  begin c.alusrca = 1; c.aluctrl = op[2:0]; end
            4'd3:  begin c.alusrca = 1; c.alusrcb = 2'd2; c.sesf = 1; end
            4'd4:  c.regwr = 1;
            4'd5:  c.alusrca = 1;
            4'd6:  c.memrd = 1;
            4'd7:  begin c.regwr = 1; c.memtoreg = 1; end
            4'd8:  c.memwr = 1;
            4'd9:  begin c.alusrca = 1; c.aluctrl = 3'b001; c.pcwc = 1; c.bneq = (op == 4'hB); end
            4'd10: begin c.alusrcb = 2'd2; c.je = 1; c.pcsrc = 2'd2; c.pcw = 1; end
            4'd11: begin c.pcsrc = 2'd1; c.pcw = 1; end
            default: ;
        endcase
        if (r) begin
            c.pcw = 0; c.pcwc = 0; c.bneq = 0; c.ird = 0; c.irwr = 0; c.memrd = 0; c.memwr = 0; c.regwr = 0;
        end
        return c;
    endfunction

    logic [3:0]       m_state;
    int               m_idx;
    logic [CNT_W-1:0] m_instret;
    logic             m_halted, m_illegal;
    logic             model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state   <= 4'd0;
            m_idx     <= 0;
            m_instret <= '0;
            m_halted  <= 1'b0;
            m_illegal <= 1'b0;
            model_ok  <= 1'b1;
        end else if (model_ok && !m_halted) begin
            if (m_idx + 1 == seq_len(bus.opcode)) begin
                m_idx     <= 0;
                m_state   <= 4'd0;
                m_instret <= m_instret + CNT_W'(1);
            end else begin
                m_idx   <= m_idx + 1;
                m_state <= seq_state(bus.opcode, m_idx + 1);
                if (seq_state(bus.opcode, m_idx + 1) == 4'd12) begin
                    m_halted <= 1'b1;
                    if (bus.opcode == 4'hF) m_illegal <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_ctl", 32'(act), 32'(exp_ctl(m_state, bus.opcode, rst)));
            check("model_state", 32'(bus.state_o), 32'(m_state));
            check("model_instret", 32'(bus.instret), 32'(m_instret));
            check("model_halted", 32'(bus.halted), 32'(m_halted));
`ifdef ILLEGAL_TRAP_EN
            check("model_illegal", 32'(bus.illegal_op), 32'(m_illegal));
`endif
        end
    end

    logic [3:0] tr_st [8];
    ctl_t       tr_c  [8];

    // Called in FETCH after its negedge; records n states starting at DECODE.
    task automatic run(input logic [3:0] op, input int n);
        bus.opcode = op;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr_st[i] = bus.state_o;
            tr_c[i]  = act;
        end
        #1;
    endtask

    function automatic logic [31:0] trace(input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[4*i +: 4] = tr_st[i];
        return v;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_instret", 32'(bus.instret), 32'd0);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.opcode = 4'h0;
        @(negedge clk);
        check("reset_pcwrite_gated", 32'(bus.PCWrite), 32'd0);
        check("reset_irwr_gated", 32'(bus.IRWr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("fetch_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("fetch_irwr", 32'(bus.IRWr), 32'd1);
        check("fetch_pcsrc", 32'(bus.PCSrc), 32'd2);
        check("fetch_state", 32'(bus.state_o), 32'd0);
        #1;

        run(4'h0, 4);
        check("add_states", trace(4), 32'h0421);
        check("add_instret", 32'(bus.instret), 32'd1);

        run(4'h8, 5);
        check("lw_states", trace(5), 32'h07651);
        for (int i = 0; i < 5; i++) begin
            check("lw_memrd", 32'(tr_c[i].memrd), 32'(i == 2));
            check("lw_regwr", 32'(tr_c[i].regwr & tr_c[i].memtoreg), 32'(i == 3));
        end
        check("lw_instret", 32'(bus.instret), 32'd2);

        run(4'hB, 3);
        check("bne_states", trace(3), 32'h091);
        check("bne_pcwc", 32'(tr_c[1].pcwc), 32'd1);
        check("bne_bneq", 32'(tr_c[1].bneq), 32'd1);
        check("bne_aluctrl", 32'(tr_c[1].aluctrl), 32'd1);
        check("bne_pcwrite", 32'(tr_c[1].pcw), 32'd0);
        check("bne_instret", 32'(bus.instret), 32'd3);

        run(4'hE, 2);
        check("halt_states", trace(2), 32'hC1);
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 4'(i);
            @(negedge clk);
            check("halt_hold_state", 32'(bus.state_o), 32'd12);
            check("halt_hold_halted", 32'(bus.halted), 32'd1);
            check("halt_hold_instret", 32'(bus.instret), 32'd3);
            #1;
        end
        bus.opcode = 4'h0;
        do_reset(1);

        run(4'h9, 2);
        check("sw_pre_states", trace(2), 32'h51);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("sw_rst_state", 32'(bus.state_o), 32'd8);
        check("sw_rst_memwr", 32'(bus.MemWr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("sw_rst_next_state", 32'(bus.state_o), 32'd0);
        check("sw_rst_instret", 32'(bus.instret), 32'd0);
        #1;

        run(4'h7, 4);
        check("addi_states", trace(4), 32'h0431);
        check("addi_sesf", 32'(tr_c[1].sesf), 32'd1);
        check("addi_r1src", 32'(tr_c[1].r1src), 32'd2);
        run(4'h5, 4);
        check("nand_aluctrl", 32'(tr_c[1].aluctrl), 32'd5);
        run(4'h9, 4);
        check("sw_states", trace(4), 32'h0851);
        check("sw_memwr", 32'(tr_c[2].memwr), 32'd1);
        run(4'hA, 3);
        check("beq_bneq", 32'(tr_c[1].bneq), 32'd0);
        check("beq_pcwc", 32'(tr_c[1].pcwc), 32'd1);
        run(4'hC, 3);
        check("jmp_states", trace(3), 32'h0A1);
        check("jmp_je_pcw", 32'({tr_c[1].je, tr_c[1].pcw}), 32'd3);
        run(4'hD, 3);
        check("jr_states", trace(3), 32'h0B1);
        check("jr_pcsrc", 32'(tr_c[1].pcsrc), 32'd1);
        check("mix_instret", 32'(bus.instret), 32'd6);

        do_reset(2);
        for (int i = 0; i < 255; i++) run(4'hD, 3);
        check("instret_max", 32'(bus.instret), 32'hFF);
        run(4'hD, 3);
        check("instret_wrap", 32'(bus.instret), 32'h00);

`ifdef ILLEGAL_TRAP_EN
        run(4'hF, 2);
        check("illegal_states", trace(2), 32'hC1);
        check("illegal_op", 32'(bus.illegal_op), 32'd1);
        check("illegal_halted", 32'(bus.halted), 32'd1);
`else
        run(4'hF, 2);
        check("illegal_nop_states", trace(2), 32'h01);
        check("illegal_nop_instret", 32'(bus.instret), 32'd1);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
